// File: rtl/fifo_loader.sv
// Streams vector B and the NUM_A rows of matrix A from word memory into the
// B FIFO and the per-row A FIFOs, one element per cycle, least-significant element first.
module fifo_loader #(
   parameter int          DATA_WIDTH = 8,
   parameter int          NUM_A      = 8,
   parameter logic [31:0] A_BASE     = 32'h0000_0000,
   parameter logic [31:0] B_BASE     = 32'h0000_0100
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic [31:0]                 mem_address,
   output logic                        mem_read,
   input  logic                        mem_waitrequest,
   input  logic [DATA_WIDTH*8-1:0]     mem_readdata,
   input  logic                        mem_readdatavalid,
   output logic [DATA_WIDTH*NUM_A-1:0] a_wrdata,
   output logic [NUM_A-1:0]            a_wrreq,
   input  logic [NUM_A-1:0]            a_wrfull,
   output logic [DATA_WIDTH-1:0]       b_wrdata,
   output logic                        b_wrreq,
   input  logic                        b_wrfull
);

   localparam int W_W = $clog2(NUM_A + 1);
   localparam logic [W_W-1:0] LAST_W = W_W'(NUM_A);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]              state;
   logic [W_W-1:0]          w_cnt;
   logic [2:0]              k_cnt;
   logic [DATA_WIDTH*8-1:0] word_buf;

   logic                    is_b;
   logic                    tgt_full;
   logic                    wr_fire;
   logic [DATA_WIDTH-1:0]   cur_elem;

   // Target selection: w_cnt == 0 is B, w_cnt == r+1 is A row r / lane r.
   always_comb begin
      is_b     = (w_cnt == '0);
      tgt_full = b_wrfull;
      for (int i = 0; i < NUM_A; i++) begin
         if (w_cnt == W_W'(i + 1)) tgt_full = a_wrfull[i];
      end
      cur_elem = '0;
      for (int j = 0; j < 8; j++) begin
         if (k_cnt == 3'(j)) cur_elem = word_buf[j*DATA_WIDTH +: DATA_WIDTH];
      end
      wr_fire = (state == S_WRITE) && !tgt_full;
   end

   // Outputs decode straight from state so an asynchronous reset clears them at once.
   always_comb begin
      busy        = (state != S_IDLE);
      done        = (state == S_DONE);
      mem_read    = (state == S_REQ);
      mem_address = '0;
      if (state == S_REQ) begin
         mem_address = is_b ? B_BASE
                            : A_BASE + {{(32-W_W){1'b0}}, w_cnt} - 32'd1;
      end
      b_wrreq  = wr_fire && is_b;
      b_wrdata = b_wrreq ? cur_elem : '0;
      a_wrreq  = '0;
      a_wrdata = '0;
      for (int i = 0; i < NUM_A; i++) begin
         if (wr_fire && (w_cnt == W_W'(i + 1))) begin
            a_wrreq[i]                              = 1'b1;
            a_wrdata[i*DATA_WIDTH +: DATA_WIDTH]    = cur_elem;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state    <= S_IDLE;
         w_cnt    <= '0;
         k_cnt    <= '0;
         word_buf <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  w_cnt <= '0;
                  k_cnt <= '0;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (!mem_waitrequest) state <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_readdatavalid) begin
                  word_buf <= mem_readdata;
                  k_cnt    <= '0;
                  state    <= S_WRITE;
               end
            end
            S_WRITE: begin
               // A full target simply holds k_cnt, so the element is retried next cycle.
               if (wr_fire) begin
                  k_cnt <= k_cnt + 3'd1;
                  if (k_cnt == 3'd7) begin
                     if (w_cnt < LAST_W) begin
                        w_cnt <= w_cnt + 1'b1;
                        state <= S_REQ;
                     end else begin
                        state <= S_DONE;
                     end
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_loader.sv
// Directed bench for fifo_loader: memory responder, write scoreboard and a
// per-cycle protocol monitor, driven by a scenario table plus hand-written sequences.
module tb_fifo_loader;

   localparam int          DW = 8;
   localparam int          NA = 8;
   localparam logic [31:0] AB = 32'h0000_0000;
   localparam logic [31:0] BB = 32'h0000_0100;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           busy;
   logic           done;
   logic [31:0]    mem_address;
   logic           mem_read;
   logic           mem_waitrequest;
   logic [DW*8-1:0] mem_readdata;
   logic           mem_readdatavalid;
   logic [DW*NA-1:0] a_wrdata;
   logic [NA-1:0]  a_wrreq;
   logic [NA-1:0]  a_wrfull;
   logic [DW-1:0]  b_wrdata;
   logic           b_wrreq;
   logic           b_wrfull;

   fifo_loader #(.DATA_WIDTH(DW), .NUM_A(NA), .A_BASE(AB), .B_BASE(BB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .a_wrdata(a_wrdata), .a_wrreq(a_wrreq), .a_wrfull(a_wrfull),
      .b_wrdata(b_wrdata), .b_wrreq(b_wrreq), .b_wrfull(b_wrfull)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests;
   int n_fail;

   // Memory image: B is bytes 01..08, A row r is eight copies of r.
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      logic [31:0] r;
      r = a - AB;
      if (a == BB) return 64'h0807060504030201;
      if (r < 32'(NA)) return {8{r[7:0]}};
      return 64'hDEAD_BEEF_DEAD_BEEF;
   endfunction

   // Memory responder: first read stalls stall_first cycles, data one cycle after acceptance.
   logic        clr;
   logic        rdv_m;
   logic [63:0] rdata_m;
   int          stall_seen;
   int          stall_first;
   logic        inj_rdv;
   logic [63:0] inj_data;

   assign mem_waitrequest   = mem_read && (stall_seen < stall_first);
   assign mem_readdatavalid = rdv_m | inj_rdv;
   assign mem_readdata      = inj_rdv ? inj_data : rdata_m;

   always @(posedge clk) begin
      if (clr) begin
         stall_seen <= 0;
         rdv_m      <= 1'b0;
      end else begin
         rdv_m <= mem_read && !mem_waitrequest;
         if (mem_read && !mem_waitrequest) rdata_m <= mem_word(mem_address);
         if (mem_read && mem_waitrequest) stall_seen <= stall_seen + 1;
      end
   end

   // Scoreboard and protocol monitor, sampled mid-cycle.
   int          n_reads, n_rdcyc, n_done, n_viol, b_cnt;
   int          a_cnt [NA];
   logic [7:0]  b_got [16];
   logic [7:0]  a_got [NA][16];
   logic [31:0] addr_got [16];

   always @(negedge clk) begin
      if (clr) begin
         n_reads = 0; n_rdcyc = 0; n_done = 0; b_cnt = 0;
         for (int i = 0; i < NA; i++) a_cnt[i] = 0;
      end else begin
         if (mem_read) n_rdcyc++;
         if (mem_read && !mem_waitrequest) begin
            if (n_reads < 16) addr_got[n_reads] = mem_address;
            n_reads++;
         end
         if (done) n_done++;
         if (b_wrreq) begin
            if (b_cnt < 16) b_got[b_cnt] = b_wrdata;
            b_cnt++;
         end else if (b_wrdata != '0) n_viol++;
         for (int i = 0; i < NA; i++) begin
            if (a_wrreq[i]) begin
               if (a_cnt[i] < 16) a_got[i][a_cnt[i]] = a_wrdata[i*DW +: DW];
               a_cnt[i]++;
            end else if (a_wrdata[i*DW +: DW] != '0) n_viol++;
         end
      end
      if ($countones({a_wrreq, b_wrreq}) > 1) n_viol++;
      if (b_wrreq && b_wrfull) n_viol++;
      if ((a_wrreq & a_wrfull) != '0) n_viol++;
   end

   function automatic logic [63:0] pack_b();
      logic [63:0] p;
      p = '0;
      for (int j = 0; j < 8; j++) p[j*8 +: 8] = b_got[j];
      return p;
   endfunction

   function automatic logic [63:0] pack_a(input int r);
      logic [63:0] p;
      p = '0;
      for (int j = 0; j < 8; j++) p[j*8 +: 8] = a_got[r][j];
      return p;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_sb();
      @(posedge clk); #1;
      clr = 1'b1; b_wrfull = 1'b0; a_wrfull = '0; stall_first = 0;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   // Leaves the bench at the first REQ cycle (cycle 0 of the load).
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (done) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic set_full(input int tgt, input logic v);
      if (tgt == 0) b_wrfull = v;
      else a_wrfull[tgt-1] = v;
   endtask

   task automatic drive_full(input int tgt, input int from, input int to);
      if (tgt >= 0) begin
         repeat (from) @(posedge clk);
         #1 set_full(tgt, 1'b1);
         repeat (to - from + 1) @(posedge clk);
         #1 set_full(tgt, 1'b0);
      end
   endtask

   task automatic check_data(input string tag);
      chk({tag, " b_count"}, 64'(b_cnt), 64'd8);
      chk({tag, " b_data"}, pack_b(), 64'h0807060504030201);
      for (int r = 0; r < NA; r++) begin
         chk($sformatf("%s a%0d_count", tag, r), 64'(a_cnt[r]), 64'd8);
         chk($sformatf("%s a%0d_data", tag, r), pack_a(r), {8{8'(r)}});
      end
      chk({tag, " addr_b"}, 64'(addr_got[0]), 64'(BB));
      for (int r = 0; r < NA; r++)
         chk($sformatf("%s addr_a%0d", tag, r), 64'(addr_got[r+1]), 64'(AB + 32'(r)));
   endtask

   typedef struct {
      string name;
      int    stall;
      int    full_tgt;
      int    full_from;
      int    full_to;
      int    exp_cyc;
      int    exp_rdcyc;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      n_tests = 0; n_fail = 0; n_viol = 0;
      rst_n = 1'b1; start = 1'b0; clr = 1'b0;
      a_wrfull = '0; b_wrfull = 1'b0; stall_first = 0;
      inj_rdv = 1'b0; inj_data = '0;

      // Cycle numbers count from the first REQ cycle (cycle 0) of the load.
      vecs[0] = '{"nominal", 0, -1, 0, 0, 90, 9};
      vecs[1] = '{"wait5",   5, -1, 0, 0, 95, 14};
      vecs[2] = '{"bfull",   0,  0, 6, 8, 93, 9};
      vecs[3] = '{"afull2",  0,  3, 33, 34, 92, 9};

      #1;
      chk("reset_ctrl", 64'({busy, done, mem_read, a_wrreq, b_wrreq, b_wrdata, mem_address}), 64'd0);
      chk("reset_adata", 64'(a_wrdata), 64'd0);
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("start_in_reset", 64'(busy), 64'd0);
      start = 1'b0;
      rst_n = 1'b0;

      for (int v = 0; v < 4; v++) begin
         clear_sb();
         stall_first = vecs[v].stall;
         pulse_start();
         chk({vecs[v].name, " first_addr"}, 64'({busy, mem_read, mem_address}), 64'({2'b11, BB}));
         fork
            wait_done(cyc);
            drive_full(vecs[v].full_tgt, vecs[v].full_from, vecs[v].full_to);
         join
         chk({vecs[v].name, " done_cycle"}, 64'(cyc), 64'(vecs[v].exp_cyc));
         repeat (3) @(negedge clk);
         chk({vecs[v].name, " reads"}, 64'(n_reads), 64'd9);
         chk({vecs[v].name, " read_cycles"}, 64'(n_rdcyc), 64'(vecs[v].exp_rdcyc));
         chk({vecs[v].name, " done_pulses"}, 64'(n_done), 64'd1);
         chk({vecs[v].name, " idle_after"}, 64'(busy), 64'd0);
         check_data(vecs[v].name);
         chk({vecs[v].name, " protocol"}, 64'(n_viol), 64'd0);
      end

      // Second start mid-load must be ignored.
      clear_sb();
      pulse_start();
      fork
         wait_done(cyc);
         begin
            repeat (20) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
         end
      join
      chk("restart done_cycle", 64'(cyc), 64'd90);
      repeat (20) @(negedge clk);
      chk("restart reads", 64'(n_reads), 64'd9);
      chk("restart done_pulses", 64'(n_done), 64'd1);
      chk("restart idle", 64'(busy), 64'd0);

      // Asynchronous reset during the WRITE phase of row 3 (cycles 42..49).
      clear_sb();
      pulse_start();
      repeat (45) @(posedge clk);
      #1 chk("pre_reset lane3", 64'(a_wrreq), 64'h08);
      #1 rst_n = 1'b1;
      #1;
      chk("midreset_ctrl", 64'({busy, done, mem_read, a_wrreq, b_wrreq, b_wrdata, mem_address}), 64'd0);
      chk("midreset_adata", 64'(a_wrdata), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 inj_rdv = 1'b1; inj_data = 64'hA5A5_A5A5_A5A5_A5A5;
      @(posedge clk); #1 inj_rdv = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_reset idle", 64'(busy), 64'd0);
      chk("post_reset reads", 64'(n_reads), 64'd5);
      chk("post_reset lane3", 64'(a_cnt[3]), 64'd3);
      chk("post_reset lane4", 64'(a_cnt[4]), 64'd0);
      clear_sb();
      pulse_start();
      wait_done(cyc);
      chk("reload done_cycle", 64'(cyc), 64'd90);
      repeat (3) @(negedge clk);
      check_data("reload");
      chk("final protocol", 64'(n_viol), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
